// File: rtl/pattern_scheduler_pkg.sv
// Shared types and defaults for the table-driven pattern scheduler.
// State encodings are 2-bit so they match the other sequencers in this codebase.
package pattern_scheduler_pkg;

  localparam int DEFAULT_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    PS_IDLE   = 2'd0,
    PS_RUN    = 2'd1,
    PS_FINISH = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pattern_scheduler_step_timer.sv
// Down-counter for one step's hold time.
// A load of duration D yields exactly max(D,1) cycles before expiry is seen.
module step_timer
  import pattern_scheduler_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] duration,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count;

  assign expired = (count == '0);

  // A zero duration is treated as one cycle, so it loads the same value as D=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (duration == '0) ? '0 : duration - CNT_WIDTH'(1);
    end else if (enable && !expired) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Table-driven sequencer for one timed output line: plays (level, duration) steps
// 0..last, optionally looping, with a start/stop/done handshake.
//
// state  | meaning
// IDLE   | out low, table writable, waiting for start
// RUN    | playing steps; out follows the current step's level
// FINISH | one-cycle done pulse after a non-looping pass
module pattern_scheduler
  import pattern_scheduler_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter int NUM_STEPS = 4,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic                 cfg_level,
  input  logic [CNT_WIDTH-1:0] cfg_duration,
  input  logic [IDX_W-1:0]     cfg_last,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  output logic                 out,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     step_idx
);

  ps_state_e            state_q, state_d;
  logic [NUM_STEPS-1:0] level_q;
  logic [CNT_WIDTH-1:0] dur_q [NUM_STEPS];
  logic [IDX_W-1:0]     idx_q, idx_d, last_q, last_d, next_idx;
  logic                 out_q, out_d, done_q, done_d, busy_q, busy_d;
  logic                 start_ok;
  logic                 timer_load, timer_expired;
  logic [CNT_WIDTH-1:0] timer_dur;

  assign start_ok = start && !stop && (state_q == PS_IDLE);
  assign next_idx = idx_q + IDX_W'(1);

  // The table is frozen while playing, including the edge that accepts start.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        dur_q[i] <= CNT_WIDTH'(1);
      end
    end else if (cfg_we && (state_q != PS_RUN) && !start_ok) begin
      level_q[cfg_addr] <= cfg_level;
      dur_q[cfg_addr]   <= cfg_duration;
    end
  end

  step_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .enable   (state_q == PS_RUN),
    .duration (timer_dur),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PS_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_STEPS - 1);
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    out_d      = out_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_dur  = dur_q[0];
    unique case (state_q)
      PS_IDLE: begin
        out_d = 1'b0;
        if (start_ok) begin
          state_d    = PS_RUN;
          idx_d      = '0;
          last_d     = cfg_last;
          out_d      = level_q[0];
          timer_load = 1'b1;
          timer_dur  = dur_q[0];
        end
      end
      PS_RUN: begin
        if (stop) begin
          state_d = PS_IDLE;
          out_d   = 1'b0;
        end else if (timer_expired) begin
          // Next step is loaded on the expiry edge so steps abut with no gap.
          if (idx_q != last_q) begin
            idx_d      = next_idx;
            out_d      = level_q[next_idx];
            timer_load = 1'b1;
            timer_dur  = dur_q[next_idx];
          end else if (loop_en) begin
            idx_d      = '0;
            out_d      = level_q[0];
            timer_load = 1'b1;
            timer_dur  = dur_q[0];
          end else begin
            state_d = PS_FINISH;
            out_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      PS_FINISH: begin
        state_d = PS_IDLE;
        out_d   = 1'b0;
      end
      default: begin
        state_d = PS_IDLE;
        out_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == PS_RUN);
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule
